// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding and
// default bus widths.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    // S_CPU: CPU owns the port, host may be granted.
    // S_ACK: host completion cycle, CPU guaranteed the port.
    typedef enum logic {
        S_CPU = 1'b0,
        S_ACK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational 2:1 selection of the DMEM request between CPU and host.
// Ports:
//   sel_host            - 1 selects the host request
//   cpu_* / host_*      - the two requester buses
//   mux_ena/r/w/addr/wdata - selected DMEM request
module dmem_port_mux
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              sel_host,
    input  logic              cpu_ena,
    input  logic              cpu_r,
    input  logic              cpu_w,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              mux_ena,
    output logic              mux_r,
    output logic              mux_w,
    output logic [ADDR_W-1:0] mux_addr,
    output logic [DATA_W-1:0] mux_wdata
);

    // Host access is always a full enable with exactly one strobe.
    always_comb begin
        mux_ena   = cpu_ena;
        mux_r     = cpu_r;
        mux_w     = cpu_w;
        mux_addr  = cpu_addr;
        mux_wdata = cpu_wdata;
        if (sel_host) begin
            mux_ena   = 1'b1;
            mux_r     = ~host_we;
            mux_w     = host_we;
            mux_addr  = host_addr;
            mux_wdata = host_wdata;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (priority) and a host/debug
// port. A waiting host is granted after at most MAX_WAIT lost cycles; the
// CPU is stalled in the host's grant cycle and guaranteed the following one.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   cpu_*               - CPU DMEM request; cpu_rdata/cpu_stall back to CPU
//   host_*              - host request/handshake; host_ack/host_rdata registered
//   dm_*                - DMEM port
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ena,
    input  logic              cpu_r,
    input  logic              cpu_w,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              dm_ena,
    output logic              dm_r,
    output logic              dm_w,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata
);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              host_ack_q, host_ack_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic              wait_full_c;
    logic              host_gnt_c;
    logic              mux_ena, mux_r, mux_w;

    assign wait_full_c = (wait_cnt_q == CNT_W'(MAX_WAIT));
    assign host_gnt_c  = host_req & (state_q == S_CPU) & (~cpu_ena | wait_full_c);

    dmem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel_host   (host_gnt_c),
        .cpu_ena    (cpu_ena),
        .cpu_r      (cpu_r),
        .cpu_w      (cpu_w),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .mux_ena    (mux_ena),
        .mux_r      (mux_r),
        .mux_w      (mux_w),
        .mux_addr   (dm_addr),
        .mux_wdata  (dm_wdata)
    );

    // Strobes are killed while reset is asserted so no write slips through.
    assign dm_ena     = mux_ena & rst;
    assign dm_r       = mux_r & rst;
    assign dm_w       = mux_w & rst;
    assign cpu_stall  = host_gnt_c & cpu_ena & rst;
    assign cpu_rdata  = dm_rdata;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

    // Next-state, wait counter and host response.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        unique case (state_q)
            S_CPU: begin
                if (host_gnt_c) begin
                    state_d    = S_ACK;
                    host_ack_d = 1'b1;
                    wait_cnt_d = '0;
                    if (!host_we) begin
                        host_rdata_d = dm_rdata;
                    end
                end else if (host_req) begin
                    if (!wait_full_c) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            S_ACK: begin
                state_d = S_CPU;
                if (!host_req) begin
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_CPU;
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_CPU;
            wait_cnt_q   <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

endmodule
